decode_imm_controller: RTL

- Decode-stage controller that owns the shared combinational immediate extender.
- Accepts instructions from fetch over a valid/ready handshake and buffers them in a 1-entry output register plus a 1-entry skid buffer.
- For each instruction it selects the extender input and the ImmSrc mode, then registers the extended immediate toward execute.
- Flags unsupported opcodes and halts intake until a flush.

---
 rtl/decode_imm_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/decode_imm_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | decode_imm_controller: decode-stage intake buffer owning the shared     |
// | immediate extender. Revision: 1.0                                       |
// +------------------------------------------------------------------------+

package HighLevelControl;
  typedef enum logic [1:0] {
    Imm11t0 = 2'd0,
    Imm4t0  = 2'd1,
    SType   = 2'd2,
    UType   = 2'd3
  } immSrc;
endpackage

module imm_extender
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32
) (
  input  logic [31:7]          Instr,
  input  immSrc                ImmSrc,
  output logic [BIT_COUNT-1:0] ImmExt
);

  // Sign fill first, then overlay the encoded field, so any BIT_COUNT >= 32 works.
  always_comb begin
    ImmExt = {BIT_COUNT{Instr[31]}};
    case (ImmSrc)
      Imm11t0: ImmExt[11:0] = Instr[31:20];
      Imm4t0: begin
        ImmExt      = '0;
        ImmExt[4:0] = Instr[24:20];
      end
      SType:   ImmExt[11:0] = {Instr[31:25], Instr[11:7]};
      UType:   ImmExt[31:0] = {Instr[31:12], 12'h000};
      default: ImmExt = '0;
    endcase
  end

endmodule

module decode_imm_controller
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 InstrValidF,
  input  logic [WORD_SIZE-1:0] InstrF,
  output logic                 InstrReadyF,
  input  logic                 FlushD,
  input  logic                 ReadyE,
  output logic                 ValidE,
  output logic [WORD_SIZE-1:0] InstrE,
  output immSrc                ImmSrcE,
  output logic [BIT_COUNT-1:0] ImmE,
  output logic                 UsesImmE,
  output logic                 IllegalE
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] skid_q, skid_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [BIT_COUNT-1:0] imm_q, imm_d;
  immSrc                imm_src_q, imm_src_d;
  logic                 uses_imm_q, uses_imm_d;
  logic                 illegal_q, illegal_d;
  logic                 halt_q, halt_d;

  logic [WORD_SIZE-1:0] sel_instr;
  immSrc                sel_src;
  logic                 sel_uses;
  logic                 sel_illegal;
  logic [BIT_COUNT-1:0] ext_imm;
  logic                 valid;
  logic                 skid_full;
  logic                 accept;
  logic                 out_load;

  assign valid       = (state_q != ST_EMPTY);
  assign skid_full   = (state_q == ST_TWO);
  assign InstrReadyF = !skid_full && !halt_q && !FlushD;
  assign accept      = InstrValidF && InstrReadyF;
  assign out_load    = (!valid || ReadyE) && (skid_full || accept);

  // The skid entry is always older than InstrF, so it owns the extender when present.
  assign sel_instr = skid_full ? skid_q : InstrF;

  always_comb begin
    sel_src     = Imm11t0;
    sel_uses    = 1'b0;
    sel_illegal = 1'b0;
    case (sel_instr[6:0])
      7'b0010011: begin
        sel_uses = 1'b1;
        if (sel_instr[13:12] == 2'b01) sel_src = Imm4t0;
      end
      7'b0000011, 7'b1100111: sel_uses = 1'b1;
      7'b0100011: begin
        sel_uses = 1'b1;
        sel_src  = SType;
      end
      7'b0110111, 7'b0010111: begin
        sel_uses = 1'b1;
        sel_src  = UType;
      end
      7'b0110011, 7'b1100011, 7'b1101111, 7'b1110011, 7'b0001111: sel_uses = 1'b0;
      default: sel_illegal = 1'b1;
    endcase
  end

  imm_extender #(
    .BIT_COUNT(BIT_COUNT)
  ) u_imm_ext (
    .Instr (sel_instr[31:7]),
    .ImmSrc(sel_src),
    .ImmExt(ext_imm)
  );

  always_comb begin
    state_d    = state_q;
    skid_d     = skid_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    imm_src_d  = imm_src_q;
    uses_imm_d = uses_imm_q;
    illegal_d  = illegal_q;
    halt_d     = halt_q;

    if (out_load) begin
      instr_d    = sel_instr;
      imm_d      = sel_uses ? ext_imm : '0;
      imm_src_d  = sel_src;
      uses_imm_d = sel_uses;
      illegal_d  = sel_illegal;
      halt_d     = halt_q || sel_illegal;
    end

    if (accept && valid && !ReadyE) skid_d = InstrF;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !ReadyE)      state_d = ST_TWO;
        else if (ReadyE && !accept) state_d = ST_EMPTY;
      end
      ST_TWO:  if (ReadyE) state_d = ST_ONE;
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins over everything; an execute handshake this cycle has already completed.
    if (FlushD) begin
      state_d    = ST_EMPTY;
      halt_d     = 1'b0;
      uses_imm_d = 1'b0;
      illegal_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      skid_q     <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      imm_src_q  <= Imm11t0;
      uses_imm_q <= 1'b0;
      illegal_q  <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skid_q     <= skid_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      imm_src_q  <= imm_src_d;
      uses_imm_q <= uses_imm_d;
      illegal_q  <= illegal_d;
      halt_q     <= halt_d;
    end
  end

  assign ValidE   = valid;
  assign InstrE   = instr_q;
  assign ImmSrcE  = imm_src_q;
  assign ImmE     = imm_q;
  assign UsesImmE = uses_imm_q;
  assign IllegalE = illegal_q;

endmodule
`default_nettype wire
